// File: rtl/pixie_pkg.sv
// -----------------------------------------------------------------------------
// pixie_pkg
// Shared definitions for the pixie display-RAM arbiter slice.
//   PIXIE_ADDR_W / PIXIE_DATA_W : default RAM geometry (1 KB x 8)
//   grant_t                     : which requester owns the RAM this cycle
//   TAG_SCAN / TAG_HOST         : read-return routing tag values
// -----------------------------------------------------------------------------
package pixie_pkg;

  localparam int PIXIE_ADDR_W = 10;
  localparam int PIXIE_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_SCAN = 2'd2,
    GNT_HOST = 2'd3
  } grant_t;

  // One tag bit travels alongside each read so the returning RAM byte can be
  // steered to the requester that issued it.
  localparam logic TAG_SCAN = 1'b0;
  localparam logic TAG_HOST = 1'b1;

endpackage

// File: rtl/pixie_wr_fifo.sv
// -----------------------------------------------------------------------------
// pixie_wr_fifo
// Small synchronous FIFO buffering DMA capture writes until the arbiter can
// drain them into the display RAM.
//   clk, reset   : clock, asynchronous active-high reset (empties the FIFO)
//   push         : enqueue push_data this cycle (dropped when full and no pop)
//   push_data    : entry to enqueue ({addr, data})
//   pop          : dequeue head entry this cycle (ignored when empty)
//   head_data    : current head entry (combinational read)
//   full, empty  : fill status from registered occupancy
//   drop         : push arrived while full with no pop; the entry is lost
// Push and pop may coincide at any fill level; at full the pop frees the slot
// the push needs, so nothing is lost. There is no bypass path: a pushed entry
// is visible on head_data no earlier than the following cycle.
// -----------------------------------------------------------------------------
module pixie_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic pop_ok;
  logic push_ok;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  assign pop_ok  = pop && !empty;
  // At full, a same-cycle pop makes room for the incoming entry.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign head_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pixie_vram_arbiter.sv
// -----------------------------------------------------------------------------
// pixie_vram_arbiter
// Shares one single-port display RAM between DMA capture writes (buffered in
// pixie_wr_fifo), video scan-out reads and a host/debug port; one access per
// clock.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   wr_req/addr/data      : DMA byte strobe into the write FIFO
//   wr_overflow, ovf_clr  : sticky "DMA byte dropped" flag and its clear
//   scan_req/addr         : scan-out read request (held until scan_ack)
//   scan_ack              : scan request granted this cycle
//   scan_rvalid/rdata     : scan read data, 2 cycles after scan_ack
//   host_req/we/addr/wdata: host read or write request (held until host_ack)
//   host_ack              : host request granted this cycle
//   host_rvalid/rdata     : host read data, 2 cycles after host_ack
//   ram_en/we/addr/wdata  : registered RAM command, one cycle after the grant
//   ram_rdata             : RAM read data, one cycle after a read access
//
// Optional build macro PIXIE_VRAM_STATS_EN adds:
//   drop_count[7:0] : saturating count of dropped DMA bytes, cleared by ovf_clr
//   scan_stall[7:0] : saturating count of cycles scan_req waited unacked
//
// Grant priority each cycle: full FIFO drain, starved host, scan, FIFO drain,
// host, idle. The grant is combinational (acks answer the held request in the
// same cycle) and the resulting RAM command is registered.
// -----------------------------------------------------------------------------
module pixie_vram_arbiter
  import pixie_pkg::*;
#(
  parameter int ADDR_W        = PIXIE_ADDR_W,
  parameter int DATA_W        = PIXIE_DATA_W,
  parameter int WFIFO_DEPTH   = 4,
  parameter int HOST_MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_overflow,
  input  logic              ovf_clr,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_ack,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef PIXIE_VRAM_STATS_EN
  ,
  output logic [7:0]        drop_count,
  output logic [7:0]        scan_stall
`endif
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int WAIT_W  = $clog2(HOST_MAX_WAIT + 1);

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  pixie_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_req),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  grant_t            grant;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              host_starved;

  assign host_starved = (wait_cnt_reg == WAIT_W'(HOST_MAX_WAIT));

  always_comb begin
    grant = GNT_IDLE;
    // Acks are combinational, so hold them low while reset is asserted to
    // keep every output quiet during reset.
    if (reset) begin
      grant = GNT_IDLE;
    end else if (fifo_full) begin
      grant = GNT_WR;
    end else if (host_req && host_starved) begin
      grant = GNT_HOST;
    end else if (scan_req) begin
      grant = GNT_SCAN;
    end else if (!fifo_empty) begin
      grant = GNT_WR;
    end else if (host_req) begin
      grant = GNT_HOST;
    end else begin
      grant = GNT_IDLE;
    end
  end

  assign fifo_pop = (grant == GNT_WR);
  assign scan_ack = (grant == GNT_SCAN);
  assign host_ack = (grant == GNT_HOST);

  // Host wait counter: counts denied cycles of a pending host request and
  // saturates at the forcing threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (host_req && !host_ack) begin
      if (!host_starved) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM command
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= (grant != GNT_IDLE);
      unique case (grant)
        GNT_WR: begin
          ram_we    <= 1'b1;
          ram_addr  <= fifo_head[ENTRY_W-1:DATA_W];
          ram_wdata <= fifo_head[DATA_W-1:0];
        end
        GNT_SCAN: begin
          ram_we    <= 1'b0;
          ram_addr  <= scan_addr;
          ram_wdata <= '0;
        end
        GNT_HOST: begin
          ram_we    <= host_we;
          ram_addr  <= host_addr;
          ram_wdata <= host_we ? host_wdata : '0;
        end
        default: begin
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tag pipeline
  // Stage 1 lines up with the RAM access cycle, stage 2 with the cycle the RAM
  // presents ram_rdata. Reset flushes both stages so an abandoned read never
  // produces an rvalid.
  // ---------------------------------------------------------------------------
  logic tag1_valid_reg;
  logic tag1_tag_reg;
  logic tag2_valid_reg;
  logic tag2_tag_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_valid_reg <= 1'b0;
      tag1_tag_reg   <= TAG_SCAN;
      tag2_valid_reg <= 1'b0;
      tag2_tag_reg   <= TAG_SCAN;
    end else begin
      tag1_valid_reg <= (grant == GNT_SCAN) || ((grant == GNT_HOST) && !host_we);
      tag1_tag_reg   <= (grant == GNT_HOST) ? TAG_HOST : TAG_SCAN;
      tag2_valid_reg <= tag1_valid_reg;
      tag2_tag_reg   <= tag1_tag_reg;
    end
  end

  assign scan_rvalid = tag2_valid_reg && (tag2_tag_reg == TAG_SCAN);
  assign host_rvalid = tag2_valid_reg && (tag2_tag_reg == TAG_HOST);

  // Gate the raw RAM data so each port only sees bytes that belong to it.
  assign scan_rdata = scan_rvalid ? ram_rdata : '0;
  assign host_rdata = host_rvalid ? ram_rdata : '0;

  // ---------------------------------------------------------------------------
  // Sticky overflow flag: a drop in the same cycle as ovf_clr keeps it set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_overflow <= 1'b0;
    end else if (fifo_drop) begin
      wr_overflow <= 1'b1;
    end else if (ovf_clr) begin
      wr_overflow <= 1'b0;
    end
  end

`ifdef PIXIE_VRAM_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  logic [7:0] drop_count_reg;
  logic [7:0] scan_stall_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_reg <= '0;
    end else if (ovf_clr) begin
      // The clear happens first; a coincident drop is counted afterwards.
      drop_count_reg <= {7'd0, fifo_drop};
    end else if (fifo_drop && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_stall_reg <= '0;
    end else if (scan_req && !scan_ack && (scan_stall_reg != 8'hFF)) begin
      scan_stall_reg <= scan_stall_reg + 1'b1;
    end
  end

  assign drop_count = drop_count_reg;
  assign scan_stall = scan_stall_reg;
`endif

endmodule

// File: tb/tb_pixie_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixie_vram_arbiter
// Directed scenarios followed by random traffic. A reference model samples the
// requests each cycle, applies the grant priority rules with a queue for the
// write FIFO and a byte array for the RAM contents, and pushes expected read
// data into per-port scoreboards; a separate monitor pops them when rvalid
// appears.
// -----------------------------------------------------------------------------
module tb_pixie_vram_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXW  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_overflow;
  logic          ovf_clr;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_ack;
  logic          scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef PIXIE_VRAM_STATS_EN
  logic [7:0]    drop_count;
  logic [7:0]    scan_stall;
`endif

  always #5 clk = ~clk;

  pixie_vram_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .WFIFO_DEPTH   (DEPTH),
    .HOST_MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_overflow (wr_overflow),
    .ovf_clr     (ovf_clr),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .scan_ack    (scan_ack),
    .scan_rvalid (scan_rvalid),
    .scan_rdata  (scan_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
`ifdef PIXIE_VRAM_STATS_EN
    ,
    .drop_count  (drop_count),
    .scan_stall  (scan_stall)
`endif
  );

  // Known initial RAM image shared by the RAM model and the reference model.
  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 3) ^ 8'h5C);
  endfunction

  // ---------------------------------------------------------------------------
  // Single-port synchronous RAM
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram_mem [1024];
  bit            ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_byte(i);
      ram_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           sb_scan[$];
  rd_t           sb_host[$];
  logic [17:0]   mdl_fifo[$];
  logic [DW-1:0] mdl_mem [1024];
  bit            mdl_init_done = 1'b0;
  int            mdl_wait = 0;
  bit            mdl_ovf = 1'b0;
  bit            exp_en = 1'b0;
  bit            exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wd = '0;
  int            g;       // 0 idle, 1 DMA write, 2 scan, 3 host
  bit            drop;

  always @(negedge clk) begin
    if (!mdl_init_done) begin
      for (int i = 0; i < 1024; i++) mdl_mem[i] = init_byte(i);
      mdl_init_done = 1'b1;
    end
    if (reset) begin
      chk("reset_outputs",
          {scan_ack, host_ack, scan_rvalid, host_rvalid, scan_rdata, host_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, wr_overflow}, 64'd0);
      mdl_fifo.delete();
      sb_scan.delete();
      sb_host.delete();
      mdl_wait = 0;
      mdl_ovf  = 1'b0;
      exp_en   = 1'b0;
      exp_we   = 1'b0;
    end else begin
      // RAM command issued for the previous cycle's grant.
      chk("ram_en", ram_en, exp_en);
      if (exp_en) begin
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        if (exp_we) begin
          chk("ram_wdata", ram_wdata, exp_wd);
          mdl_mem[exp_addr] = exp_wd;  // write lands in this cycle
        end
      end
      chk("wr_overflow", wr_overflow, mdl_ovf);

      if (mdl_fifo.size() == DEPTH)             g = 1;
      else if (host_req && mdl_wait == MAXW)    g = 3;
      else if (scan_req)                        g = 2;
      else if (mdl_fifo.size() > 0)             g = 1;
      else if (host_req)                        g = 3;
      else                                      g = 0;

      chk("scan_ack", scan_ack, g == 2);
      chk("host_ack", host_ack, g == 3);

      exp_en = (g != 0);
      exp_we = 1'b0;
      case (g)
        1: begin
          {exp_addr, exp_wd} = mdl_fifo.pop_front();
          exp_we = 1'b1;
        end
        2: begin
          exp_addr = scan_addr;
          sb_scan.push_back('{mdl_mem[scan_addr], cyc + 2});
        end
        3: begin
          exp_addr = host_addr;
          if (host_we) begin
            exp_we = 1'b1;
            exp_wd = host_wdata;
          end else begin
            sb_host.push_back('{mdl_mem[host_addr], cyc + 2});
          end
        end
        default: ;
      endcase

      if (host_req && g != 3) mdl_wait = (mdl_wait < MAXW) ? mdl_wait + 1 : MAXW;
      else                    mdl_wait = 0;

      drop = 1'b0;
      if (wr_req) begin
        if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back({wr_addr, wr_data});
        else                         drop = 1'b1;
      end
      if (drop)         mdl_ovf = 1'b1;
      else if (ovf_clr) mdl_ovf = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return monitor
  // ---------------------------------------------------------------------------
  rd_t mon_e;
  bit  mon_exp_scan;
  bit  mon_exp_host;

  always @(negedge clk) begin
    if (!reset) begin
      mon_exp_scan = (sb_scan.size() > 0) && (sb_scan[0].due == cyc);
      chk("scan_rvalid", scan_rvalid, mon_exp_scan);
      if (mon_exp_scan) begin
        mon_e = sb_scan.pop_front();
        chk("scan_rdata", scan_rdata, mon_e.data);
        $display("scan read  cycle=%0d data=0x%02h", cyc, scan_rdata);
      end
      mon_exp_host = (sb_host.size() > 0) && (sb_host[0].due == cyc);
      chk("host_rvalid", host_rvalid, mon_exp_host);
      if (mon_exp_host) begin
        mon_e = sb_host.pop_front();
        chk("host_rdata", host_rdata, mon_e.data);
        $display("host read  cycle=%0d data=0x%02h", cyc, host_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit sa;
  bit ha;
  int last_host_ack_cyc = -1;
  int t0;
  int n;

  // Advance one cycle; a request that was acked is retired, strobes are cleared.
  task automatic step();
    @(negedge clk);
    sa = scan_ack;
    ha = host_ack;
    if (ha) last_host_ack_cyc = cyc;
    @(posedge clk);
    #1;
    if (sa) scan_req = 1'b0;
    if (ha) host_req = 1'b0;
    wr_req  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic until_ack(input bit host);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(host ? ha : sa) && k < 60);
    chk(host ? "host_ack_wait" : "scan_ack_wait", host ? ha : sa, 1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; ovf_clr = 1'b0;
    scan_req = 1'b0; scan_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) step();

    // Write path: byte lands at N+2, then read back through scan-out.
    wr_req = 1'b1; wr_addr = 10'h010; wr_data = 8'hA5;
    $display("dma write  cycle=%0d addr=0x010 data=0xA5", cyc);
    step();
    repeat (3) step();
    scan_req = 1'b1; scan_addr = 10'h010;
    until_ack(1'b0);
    repeat (4) step();

    // FIFO fills behind a constant scan request; forced drain avoids a drop.
    for (int i = 0; i < 8; i++) begin
      scan_req = 1'b1;
      scan_addr = rand_addr();
      if (i < 5) begin
        wr_req = 1'b1; wr_addr = rand_addr(); wr_data = 8'($urandom);
      end
      step();
    end
    if (scan_req) until_ack(1'b0);
    chk("fifo_full_no_drop", wr_overflow, 0);
    repeat (6) step();

    // Starvation: host forced after exactly MAXW denied cycles, twice in a row.
    for (int r = 0; r < 2; r++) begin
      scan_req = 1'b1; scan_addr = rand_addr();
      host_req = 1'b1; host_we = 1'b0; host_addr = rand_addr();
      t0 = cyc;
      n = 0;
      do begin
        scan_req = 1'b1;
        step();
        n++;
      end while (!ha && n < 40);
      chk("starve_latency", last_host_ack_cyc - t0, MAXW);
      $display("host forced cycle=%0d after %0d cycles", last_host_ack_cyc, last_host_ack_cyc - t0);
    end
    if (scan_req) until_ack(1'b0);
    repeat (6) step();

    // Arbitration order with the FIFO empty.
    scan_req = 1'b1; scan_addr = 10'h021;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h022;
    step();
    chk("arb_scan_first", {sa, ha}, 2'b10);
    step();
    chk("arb_host_next", {sa, ha}, 2'b01);
    repeat (4) step();

    // Reset while a host read is in flight.
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h033;
    step();
    chk("mid_read_ack", ha, 1);
    reset = 1'b1;
    scan_req = 1'b1; scan_addr = 10'h044;
    step();
    step();
    reset = 1'b0;
    scan_req = 1'b0;
    repeat (5) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!scan_req && $urandom_range(0, 2) == 0) begin
        scan_req = 1'b1; scan_addr = rand_addr();
      end
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom); host_addr = rand_addr();
        host_wdata = 8'($urandom);
      end
      wr_req  = 1'($urandom_range(0, 1));
      wr_addr = rand_addr();
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    for (int i = 0; i < 200 && (scan_req || host_req); i++) step();
    chk("drain_requests", {scan_req, host_req}, 0);
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
